gen_scheduler: RTL

Sequences the Game of Life update engine. Derives generation timing from the 50 MHz clock, issues one-cycle start pulses to the engine, waits for its done pulse, and reports completed generations to the display path. It supports run, pause, single-step and clear, and the board's front panel is wired to it. It replaces direct use of the fixed 1 Hz pulse with a selectable generation rate.

---
 rtl/gen_scheduler_pkg.sv | 14 +
 rtl/gen_scheduler_if.sv | 24 ++
 rtl/gen_scheduler_tick_gen.sv | 25 ++
 rtl/gen_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/gen_scheduler_pkg.sv
// Shared types and constants for the Game of Life generation scheduler.
package gol_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, START, BUSY, CLR_START, CLEARING} state_t;

  localparam int GEN_CNT_W = 16;
  localparam int SPEED_MAX = 4;

  // Base ticks per generation: 16 >> min(speed, SPEED_MAX).
  function automatic logic [4:0] interval_len(input logic [2:0] speed);
    logic [2:0] s;
    s = (speed > 3'(SPEED_MAX)) ? 3'(SPEED_MAX) : speed;
    return 5'd16 >> s;
  endfunction
endpackage

// File: rtl/gen_scheduler_if.sv
// Front panel, engine handshake and display-path signals of the scheduler.
interface gen_scheduler_if;
  import gol_pkg::*;
  logic                 run;
  logic                 step;
  logic                 clear;
  logic [2:0]           speed;
  logic                 gen_start;
  logic                 clr_start;
  logic                 gen_done;
  logic                 frame_swap;
  logic [GEN_CNT_W-1:0] gen_count;
  logic                 busy;
  logic                 fault;

  modport master (
    output run, step, clear, speed, gen_done,
    input  gen_start, clr_start, frame_swap, gen_count, busy, fault
  );
  modport slave (
    input  run, step, clear, speed, gen_done,
    output gen_start, clr_start, frame_swap, gen_count, busy, fault
  );
endinterface

// File: rtl/gen_scheduler_tick_gen.sv
// Free-running compare-and-reload counter; registered one-cycle pulse every DIV cycles.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/gen_scheduler.sv
// Generation sequencer: paces engine start pulses from the base tick, handles
// run/pause/step/clear requests, counts generations and flags engine timeouts.
module gen_scheduler
  import gol_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BASE_HZ = 16,
  parameter int TIMEOUT = 1048576
) (
  input logic             clk,
  input logic             rst,
  gen_scheduler_if.slave  sif
);
  localparam int BASE_DIV = CLK_HZ / BASE_HZ;
  localparam int TW       = $clog2(TIMEOUT + 1);

  state_t               state, state_d;
  logic                 tick;
  logic                 step_pend, clear_pend, step_pend_d, clear_pend_d;
  logic                 step_req, clear_req;
  logic [4:0]           ilen, icnt;
  logic [TW-1:0]        tcnt;
  logic                 in_wait, expire, done_ok, timeout, arm_entry;
  logic [GEN_CNT_W-1:0] gen_count_q, gen_count_d;
  logic                 gen_start_q, clr_start_q, frame_swap_q, busy_q, fault_q;
  logic                 gen_start_d, clr_start_d, busy_d, fault_d;

  tick_gen #(.DIV(BASE_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  // A pulse arriving in the consuming cycle counts as pending already.
  assign step_req  = step_pend | sif.step;
  assign clear_req = clear_pend | sif.clear;
  assign in_wait   = (state == BUSY) || (state == CLEARING);
  assign expire    = (state == ARMED) && tick && (icnt == ilen - 5'd1);
  assign done_ok   = in_wait && sif.gen_done;
  assign timeout   = in_wait && !sif.gen_done && (tcnt == TW'(TIMEOUT - 1));
  assign arm_entry = (state_d == ARMED) && (state != ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      step_pend  <= 1'b0;
      clear_pend <= 1'b0;
    end else begin
      state      <= state_d;
      step_pend  <= step_pend_d;
      clear_pend <= clear_pend_d;
    end
  end

  always_comb begin
    state_d      = state;
    step_pend_d  = step_req;
    clear_pend_d = clear_req;
    case (state)
      IDLE: begin
        if (!fault_q) begin
          if (clear_req) begin
            state_d      = CLR_START;
            clear_pend_d = 1'b0;
          end else begin
            // step is consumed when paused and discarded when running
            step_pend_d = 1'b0;
            if (sif.run)       state_d = ARMED;
            else if (step_req) state_d = START;
          end
        end
      end
      ARMED: begin
        if (clear_req) begin
          state_d      = CLR_START;
          clear_pend_d = 1'b0;
        end else if (!sif.run) begin
          state_d = IDLE;
        end else begin
          step_pend_d = 1'b0;
          if (expire) state_d = START;
        end
      end
      START:     state_d = BUSY;
      CLR_START: state_d = CLEARING;
      BUSY, CLEARING: begin
        if (done_ok)      state_d = sif.run ? ARMED : IDLE;
        else if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gen_start_d = (state_d == START);
    clr_start_d = (state_d == CLR_START);
    busy_d      = (state_d == START) || (state_d == BUSY) ||
                  (state_d == CLR_START) || (state_d == CLEARING);
    fault_d     = fault_q | timeout;
    gen_count_d = gen_count_q;
    if (done_ok) gen_count_d = (state == BUSY) ? gen_count_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_start_q  <= 1'b0;
      clr_start_q  <= 1'b0;
      frame_swap_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      gen_count_q  <= '0;
    end else begin
      gen_start_q  <= gen_start_d;
      clr_start_q  <= clr_start_d;
      frame_swap_q <= done_ok;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      if (done_ok) gen_count_q <= gen_count_d;
    end
  end

  // Interval length is sampled from speed each time ARMED is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= '0;
      ilen <= 5'd16;
    end else if (arm_entry) begin
      icnt <= '0;
      ilen <= interval_len(sif.speed);
    end else if ((state == ARMED) && tick) begin
      icnt <= icnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tcnt <= '0;
    else if (in_wait) tcnt <= tcnt + 1'b1;
    else              tcnt <= '0;
  end

  assign sif.gen_start  = gen_start_q;
  assign sif.clr_start  = clr_start_q;
  assign sif.frame_swap = frame_swap_q;
  assign sif.gen_count  = gen_count_q;
  assign sif.busy       = busy_q;
  assign sif.fault      = fault_q;
endmodule
